// File: rtl/inv_share_pkg.sv
// Shared types and defaults for the inverter-sharing arbiter.
// Optional checker enabled by INV_SHARE_CHECK_EN.
package inv_share_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inv_share_arb_rr_pick.sv
// Combinational round-robin selector: search starts one past ptr.
// Used by inv_share_arb (build option INV_SHARE_CHECK_EN lives in the top).
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  always_comb begin
    logic [ID_W-1:0] idx;
    idx    = '0;
    winner = '0;
    any    = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % N_REQ);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/inv_share_arb.sv
// Round-robin sharing of one external inverter among N_REQ requesters.
// Define INV_SHARE_CHECK_EN to build the sticky err result checker.
module inv_share_arb
  import inv_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       inv_in,
  input  logic [WIDTH-1:0]       inv_out,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
`ifdef INV_SHARE_CHECK_EN
  output logic                   err,
`endif
  output logic [WIDTH-1:0]       rsp_data
);

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    cur_id_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [WIDTH-1:0]   inv_in_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [WIDTH-1:0]   rsp_data_q;

  logic [ID_W-1:0]    win;
  logic               any;
  logic [N_REQ-1:0]   gnt_d;
  logic [WIDTH-1:0]   op_d;
  logic [WIDTH-1:0]   ops [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_ops
    assign ops[g] = req_data[g*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (win),
    .any    (any)
  );

  assign gnt_d = N_REQ'(1) << win;
  assign op_d  = ops[win];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(N_REQ - 1);
      cur_id_q    <= '0;
      gnt_q       <= '0;
      inv_in_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          rsp_valid_q <= 1'b0;
          gnt_q       <= '0;
          if (any) begin
            gnt_q    <= gnt_d;
            inv_in_q <= op_d;
            cur_id_q <= win;
            ptr_q    <= win;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          // result of the shared inverter has settled by now
          rsp_data_q  <= inv_out;
          rsp_id_q    <= cur_id_q;
          rsp_valid_q <= 1'b1;
          gnt_q       <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef INV_SHARE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == BUSY && inv_out != ~inv_in_q) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

  assign gnt       = gnt_q;
  assign inv_in    = inv_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_inv_share_arb.sv
// Self-checking bench for inv_share_arb: vector table plus corner sequences.
// Checker sequence runs when INV_SHARE_CHECK_EN is defined.
module tb_inv_share_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
  } rsp_t;

  typedef struct packed {
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   gnt;
    logic [W-1:0]   inv;
    logic [IW-1:0]  id;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   inv_in;
  logic [W-1:0]   inv_out;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_data;
  logic           force_bad = 1'b0;
`ifdef INV_SHARE_CHECK_EN
  logic           err;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  rsp_t sb[$];
  vec_t tab[10];

  assign inv_out = force_bad ? inv_in : ~inv_in;

  always #5 clk = ~clk;

  inv_share_arb #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .inv_in    (inv_in),
    .inv_out   (inv_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
`ifdef INV_SHARE_CHECK_EN
    .err       (err),
`endif
    .rsp_data  (rsp_data)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_t e;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got id %0d data %0h expected none",
                 rsp_id, rsp_data);
      end else begin
        e = sb.pop_front();
        if (rsp_id !== e.id || rsp_data !== e.data) begin
          n_err++;
          $display("FAIL rsp: got id %0d data %0h expected id %0d data %0h",
                   rsp_id, rsp_data, e.id, e.data);
        end
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"}, 32'(gnt), 0);
    chk({nm, "_inv_in"}, 32'(inv_in), 0);
    chk({nm, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({nm, "_rsp_id"}, 32'(rsp_id), 0);
    chk({nm, "_rsp_data"}, 32'(rsp_data), 0);
`ifdef INV_SHARE_CHECK_EN
    chk({nm, "_err"}, 32'(err), 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tab[0] = '{4'b0001, 32'h0000005A, 4'b0001, 8'h5A, 2'd0};
    tab[1] = '{4'b0100, 32'h003C0000, 4'b0100, 8'h3C, 2'd2};
    tab[2] = '{4'b0100, 32'h00F00000, 4'b0100, 8'hF0, 2'd2};
    tab[3] = '{4'b1000, 32'h11000000, 4'b1000, 8'h11, 2'd3};
    tab[4] = '{4'b1001, 32'h33000022, 4'b0001, 8'h22, 2'd0};
    tab[5] = '{4'b1001, 32'h55000044, 4'b1000, 8'h55, 2'd3};
    tab[6] = '{4'b0110, 32'h00776600, 4'b0010, 8'h66, 2'd1};
    tab[7] = '{4'b0110, 32'h00998800, 4'b0100, 8'h99, 2'd2};
    tab[8] = '{4'b0000, 32'hDEADBEEF, 4'b0000, 8'h99, 2'd0};
    tab[9] = '{4'b1111, 32'h04030201, 4'b1000, 8'h04, 2'd3};

    do_reset();

    foreach (tab[i]) begin
      req      = tab[i].req;
      req_data = tab[i].data;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tab[i].gnt));
      chk($sformatf("v%0d_inv_in", i), 32'(inv_in), 32'(tab[i].inv));
      if (tab[i].gnt != 0) sb.push_back('{tab[i].id, ~tab[i].inv});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_gnt_clr", i), 32'(gnt), 0);
    end
    req = '0;

    // all requesters held high: grants rotate 0,1,2,3,0
    do_reset();
    req      = 4'b1111;
    req_data = 32'h03020100;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rot%0d_gnt", k), 32'(gnt), 32'(1 << (k % 4)));
      chk($sformatf("rot%0d_inv_in", k), 32'(inv_in), 32'(k % 4));
      sb.push_back('{IW'(k % 4), ~W'(k % 4)});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rot%0d_gnt_clr", k), 32'(gnt), 0);
    end
    req = '0;

    // reset in the cycle after gnt aborts the operation
    do_reset();
    req      = 4'b0100;
    req_data = 32'h00AB0000;
    @(posedge clk);
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'h4);
    rst = 1'b1;
    req = '0;
    #1;
    chk_zero("abort");
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    req      = 4'b1001;
    req_data = 32'h34000012;
    @(posedge clk);
    @(negedge clk);
    chk("post_abort_gnt", 32'(gnt), 32'h1);
    chk("post_abort_inv_in", 32'(inv_in), 32'h12);
    sb.push_back('{2'd0, 8'hED});
    req = '0;
    @(posedge clk);
    @(negedge clk);

`ifdef INV_SHARE_CHECK_EN
    do_reset();
    req       = 4'b0010;
    req_data  = 32'h00003C00;
    force_bad = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("chk_gnt", 32'(gnt), 32'h2);
    chk("chk_err_pre", 32'(err), 0);
    sb.push_back('{2'd1, 8'h3C});
    @(posedge clk);
    @(negedge clk);
    force_bad = 1'b0;
    chk("chk_err_set", 32'(err), 1);
    req      = 4'b0001;
    req_data = 32'h0000000F;
    @(posedge clk);
    @(negedge clk);
    sb.push_back('{2'd0, 8'hF0});
    req = '0;
    @(posedge clk);
    @(negedge clk);
    chk("chk_err_held", 32'(err), 1);
    do_reset();
`endif

    repeat (3) @(negedge clk);
    chk("rsp_missing", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
